// File: rtl/shift_seq_ctrl_if.sv
// Request/response and shifter-side bundle for shift_seq_ctrl.
// master = requester plus shifter environment, slave = controller.
interface shift_seq_ctrl_if #(
    parameter int AMT_W = 5
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [7:0]       data_in;
    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic [2:0]       sh_op;
    logic [1:0]       sh_shamt;
    logic [7:0]       sh_d_in;
    logic [7:0]       sh_d_out;

    modport master (
        output start, mode, amount, data_in, sh_d_out,
        input  busy, done, result, sh_op, sh_shamt, sh_d_in
    );

    modport slave (
        input  start, mode, amount, data_in, sh_d_out,
        output busy, done, result, sh_op, sh_shamt, sh_d_in
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequences an 8-bit registered shifter through LOAD and up to 3-bit
// steps to realise a shift of any distance, with start/busy/done.
module shift_seq_ctrl #(
    parameter int AMT_W   = 5,
    parameter int SAT_AMT = 8
) (
    input logic              clk,
    input logic              reset,
    shift_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE, LOAD, SHIFT, CAPTURE
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    localparam logic [AMT_W-1:0] SAT = AMT_W'(SAT_AMT);
    localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(3);

    state_t           state, state_nx;
    logic [7:0]       data_q;
    logic [1:0]       mode_q;
    logic [AMT_W-1:0] rem_q;
    logic             done_q;
    logic [7:0]       result_q;
    logic [1:0]       step;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt_sat;

    // Beyond 8 bits every shift mode saturates, so clamping is exact.
    assign amt_sat = (bus.amount > SAT) ? SAT : bus.amount;

    always_comb begin
        state_nx = state;
        step     = 2'd0;
        op       = OP_NOP;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = LOAD;
            end
            LOAD: begin
                op       = OP_LOAD;
                state_nx = (rem_q != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                step = (rem_q > MAX_STEP) ? 2'd3 : rem_q[1:0];
                unique case (mode_q)
                    2'b00:   op = OP_LSL;
                    2'b01:   op = OP_LSR;
                    2'b10:   op = OP_ASR;
                    default: op = OP_NOP;
                endcase
                if (rem_q == AMT_W'(step))
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= 8'h00;
            mode_q   <= 2'b00;
            rem_q    <= '0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
        end else begin
            state  <= state_nx;
            done_q <= (state == CAPTURE);
            if (state == CAPTURE)
                result_q <= bus.sh_d_out;
            if (state == IDLE && bus.start) begin
                data_q <= bus.data_in;
                mode_q <= bus.mode;
                rem_q  <= (bus.mode == 2'b11) ? '0 : amt_sat;
            end else if (state == SHIFT) begin
                rem_q <= rem_q - AMT_W'(step);
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.sh_op    = op;
    assign bus.sh_shamt = step;
    assign bus.sh_d_in  = data_q;
endmodule
